dl_router: RTL and testbench

- Parametrised ioctl download router between hps_io and the system core.
- Generalises the single "index < N → reset core" download handling to TARGETS independent memories, each selected by ioctl_index.
- Packs the 8-bit ioctl stream into DATA_W-wide words with byte enables, checks address bounds, holds core reset through a programmable settle window, and reports per-target load status.

---
 rtl/dl_router_if.sv | 25 ++
 rtl/dl_router.sv | 161 ++++++++++++++++
 tb/tb_dl_router.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dl_router_if.sv
// dl_router_if: ioctl byte stream in, packed target word writes out
interface dl_router_if #(
    parameter int TARGETS = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8
);
    localparam int BPW = DATA_W / 8;
    logic               ioctl_download;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic [7:0]         ioctl_index;
    logic [TARGETS-1:0] tgt_wr;
    logic [ADDR_W-1:0]  tgt_addr;
    logic [DATA_W-1:0]  tgt_data;
    logic [BPW-1:0]     tgt_be;
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  tgt_wr, tgt_addr, tgt_data, tgt_be
    );
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output tgt_wr, tgt_addr, tgt_data, tgt_be
    );
endinterface

// File: rtl/dl_router.sv
// dl_router: routes ioctl downloads to per-index memories as packed words, holding core reset
module dl_router #(
    parameter int TARGETS     = 4,
    parameter int INDEX_BASE  = 0,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    dl_router_if.slave         bus,
    output logic               core_reset,
    output logic               busy,
    output logic [TARGETS-1:0] loaded,
    output logic [TARGETS-1:0] overflow
);
    localparam int BPW = DATA_W / 8;
    localparam int LW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int TW  = TARGETS > 1 ? $clog2(TARGETS) : 1;
    localparam int CW  = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;
    state_t             state_q, state_d;
    logic [TW-1:0]      tgt_q, tgt_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]  pend_data_q, pend_data_d;
    logic [BPW-1:0]     pend_be_q, pend_be_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TARGETS-1:0] wr_q, wr_d, loaded_q, loaded_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BPW-1:0]     be_q, be_d;
    logic [24:0]        waddr;
    logic [ADDR_W-1:0]  waddr_lo;
    logic [LW-1:0]      lane;
    logic               oor, idx_ok;
    logic [7:0]         rel;
    logic [DATA_W-1:0]  lane_mask, byte_sh, st_data;
    logic [BPW-1:0]     lane_be, st_be;
    logic [TARGETS-1:0] tgt_oh, sel_oh;
    assign waddr     = bus.ioctl_addr / 25'(BPW);
    assign waddr_lo  = waddr[ADDR_W-1:0];
    assign lane      = LW'(bus.ioctl_addr % 25'(BPW));
    assign oor       = (waddr >> ADDR_W) != '0;
    assign lane_mask = DATA_W'(8'hff) << {lane, 3'b000};
    assign byte_sh   = DATA_W'(bus.ioctl_dout) << {lane, 3'b000};
    assign lane_be   = BPW'(1) << lane;
    assign st_data   = (pend_data_q & ~lane_mask) | byte_sh;
    assign st_be     = pend_be_q | lane_be;
    assign rel       = bus.ioctl_index - 8'(INDEX_BASE);
    assign idx_ok    = bus.ioctl_index >= 8'(INDEX_BASE) && {1'b0, rel} < 9'(TARGETS);
    assign tgt_oh    = TARGETS'(1) << tgt_q;
    assign sel_oh    = TARGETS'(1) << rel;
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        cnt_d       = cnt_q;
        wr_d        = '0;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        loaded_d    = loaded_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: if (bus.ioctl_download && idx_ok) begin
                state_d     = LOAD;
                tgt_d       = TW'(rel);
                loaded_d    = loaded_q & ~sel_oh;
                ovf_d       = ovf_q & ~sel_oh;
                pend_addr_d = '0;
                pend_data_d = '0;
                pend_be_d   = '0;
            end
            LOAD: begin
                if (bus.ioctl_wr) begin
                    if (oor) begin
                        ovf_d = ovf_q | tgt_oh;
                    end else if (pend_be_q != '0 && waddr_lo != pend_addr_q) begin
                        // address jump: flush the old word, new byte starts a fresh one
                        wr_d        = tgt_oh;
                        addr_d      = pend_addr_q;
                        data_d      = pend_data_q;
                        be_d        = pend_be_q;
                        pend_addr_d = waddr_lo;
                        pend_data_d = byte_sh;
                        pend_be_d   = lane_be;
                    end else if (&st_be) begin
                        wr_d        = tgt_oh;
                        addr_d      = waddr_lo;
                        data_d      = st_data;
                        be_d        = st_be;
                        pend_data_d = '0;
                        pend_be_d   = '0;
                    end else begin
                        pend_addr_d = waddr_lo;
                        pend_data_d = st_data;
                        pend_be_d   = st_be;
                    end
                end
                if (!bus.ioctl_download) state_d = FLUSH;
            end
            FLUSH: begin
                if (pend_be_q != '0) begin
                    wr_d   = tgt_oh;
                    addr_d = pend_addr_q;
                    data_d = pend_data_q;
                    be_d   = pend_be_q;
                end
                pend_data_d = '0;
                pend_be_d   = '0;
                cnt_d       = '0;
                state_d     = HOLD;
            end
            HOLD: begin
                state_d  = cnt_q == CW'(HOLD_CYCLES - 1) ? IDLE : HOLD;
                loaded_d = cnt_q == CW'(HOLD_CYCLES - 1) ? loaded_q | tgt_oh : loaded_q;
                cnt_d    = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_be_q   <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            loaded_q    <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            loaded_q    <= loaded_d;
            ovf_q       <= ovf_d;
        end
    end
    assign bus.tgt_wr   = wr_q;
    assign bus.tgt_addr = addr_q;
    assign bus.tgt_data = data_q;
    assign bus.tgt_be   = be_q;
    assign core_reset   = state_q != IDLE;
    assign busy         = state_q == LOAD || state_q == FLUSH;
    assign loaded       = loaded_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_dl_router.sv
// tb_dl_router: directed downloads with a scoreboard of expected target word writes
module tb_dl_router;
    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       core_reset, busy;
    logic [3:0] loaded, overflow;
    int         total = 0;
    int         bad   = 0;
    typedef struct packed {
        logic [3:0]  wr;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
    } exp_t;
    exp_t sb[$];
    always #5 clk_sys = ~clk_sys;
    dl_router_if #(.TARGETS(4), .ADDR_W(2), .DATA_W(16)) bus ();
    dl_router #(
        .TARGETS(4), .INDEX_BASE(0), .ADDR_W(2), .DATA_W(16), .HOLD_CYCLES(16)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .bus(bus),
        .core_reset(core_reset), .busy(busy), .loaded(loaded), .overflow(overflow)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic void expect_wr(logic [3:0] w, logic [1:0] a, logic [15:0] d, logic [1:0] b);
        sb.push_back('{w, a, d, b});
    endfunction
    always @(negedge clk_sys) begin
        if (bus.tgt_wr !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 32'(bus.tgt_wr), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_target", 32'(bus.tgt_wr), 32'(e.wr));
                chk("wr_addr", 32'(bus.tgt_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.tgt_data), 32'(e.data));
                chk("wr_be", 32'(bus.tgt_be), 32'(e.be));
            end
        end
    end
    task automatic start(input logic [7:0] idx);
        @(negedge clk_sys);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
    endtask
    task automatic finish_dl(output int n);
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        n = 0;
        while (core_reset && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
    endtask
    initial begin
        int n;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_core_reset", 32'(core_reset), 32'h0);
        chk("rst_loaded", 32'(loaded), 32'h0);
        chk("rst_wr", 32'(bus.tgt_wr), 32'h0);
        reset = 1'b0;
        // full words into target 1
        start(8'd1);
        chk("t1_core_reset", 32'(core_reset), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        expect_wr(4'b0010, 2'd0, 16'h2211, 2'b11);
        expect_wr(4'b0010, 2'd1, 16'h4433, 2'b11);
        wr_byte(25'd0, 8'h11);
        wr_byte(25'd1, 8'h22);
        wr_byte(25'd2, 8'h33);
        wr_byte(25'd3, 8'h44);
        finish_dl(n);
        chk("t1_hold_len", 32'(n), 32'd18);
        chk("t1_loaded", 32'(loaded), 32'b0010);
        // trailing partial word flushed into target 0
        start(8'd0);
        expect_wr(4'b0001, 2'd0, 16'h2211, 2'b11);
        expect_wr(4'b0001, 2'd1, 16'h0033, 2'b01);
        wr_byte(25'd0, 8'h11);
        wr_byte(25'd1, 8'h22);
        wr_byte(25'd2, 8'h33);
        finish_dl(n);
        chk("t2_idle", 32'(core_reset), 32'h0);
        chk("t2_loaded", 32'(loaded), 32'b0011);
        // address jump emits the partial word
        start(8'd1);
        chk("t3_loaded_cleared", 32'(loaded), 32'b0001);
        expect_wr(4'b0010, 2'd0, 16'h00a5, 2'b01);
        expect_wr(4'b0010, 2'd2, 16'h5b00, 2'b10);
        wr_byte(25'd0, 8'ha5);
        wr_byte(25'd5, 8'h5b);
        finish_dl(n);
        chk("t3_loaded", 32'(loaded), 32'b0011);
        // out-of-range byte, then overflow cleared by a new download
        start(8'd2);
        wr_byte(25'd8, 8'hee);
        chk("t4_overflow", 32'(overflow), 32'b0100);
        finish_dl(n);
        chk("t4_loaded", 32'(loaded), 32'b0111);
        start(8'd2);
        chk("t4_overflow_cleared", 32'(overflow), 32'b0000);
        expect_wr(4'b0100, 2'd3, 16'h0077, 2'b01);
        wr_byte(25'd6, 8'h77);
        finish_dl(n);
        chk("t4_loaded2", 32'(loaded), 32'b0111);
        // index outside the target range is ignored
        start(8'd7);
        chk("t5_core_reset", 32'(core_reset), 32'h0);
        wr_byte(25'd0, 8'h99);
        chk("t5_busy", 32'(busy), 32'h0);
        finish_dl(n);
        chk("t5_loaded", 32'(loaded), 32'b0111);
        // reset mid-load discards the partial word
        start(8'd3);
        wr_byte(25'd0, 8'h12);
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_core_reset", 32'(core_reset), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_loaded", 32'(loaded), 32'h0);
        chk("t6_wr", 32'(bus.tgt_wr), 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        start(8'd3);
        expect_wr(4'b1000, 2'd0, 16'h3412, 2'b11);
        wr_byte(25'd0, 8'h12);
        wr_byte(25'd1, 8'h34);
        finish_dl(n);
        chk("t6_hold_len", 32'(n), 32'd18);
        chk("t6_loaded", 32'(loaded), 32'b1000);
        chk("t6_overflow", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk_sys);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
